sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the single-write-port / single-read-port 16K x 16 packet SRAM between N_WR write requesters and N_RD read requesters.
- Arbitrates each port independently using round-robin.
- Registers the winning command onto the SRAM pins.
- Returns read data tagged with the requester ID after a fixed latency.
- Sits between the port-side buffer managers and the SRAM instance.

Parameters:
N_WR, 4, number of write requesters (>=2)
N_RD, 4, number of read requesters (>=2)
AW, 14, SRAM address width
DW, 16, SRAM data width
IDW, $clog2(N_RD), read requester ID width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_req_valid  in  N_WR  per-requester write request
wr_req_addr  in  N_WR*AW  packed write addresses, requester i at [i*AW +: AW]
wr_req_data  in  N_WR*DW  packed write data
wr_req_ready  out  N_WR  one-hot write grant (combinational)
rd_req_valid  in  N_RD  per-requester read request
rd_req_addr  in  N_RD*AW  packed read addresses
rd_req_ready  out  N_RD  one-hot read grant (combinational)
rsp_valid  out  1  read data valid
rsp_id  out  IDW  requester that owns rsp_data
rsp_data  out  DW  read data (driven from mem_dout)
mem_wr_en  out  1  SRAM write enable
mem_wr_addr  out  AW  SRAM write address
mem_din  out  DW  SRAM write data
mem_rd_en  out  1  SRAM read enable
mem_rd_addr  out  AW  SRAM read address
mem_dout  in  DW  SRAM read data (valid one cycle after mem_rd_en)

Behaviour:
- Reset (async assert, sync release):
  - mem_wr_en=0, mem_rd_en=0, mem_wr_addr=0, mem_rd_addr=0, mem_din=0.
  - rsp_valid=0, rsp_id=0.
  - Both RR pointers = last index, so requester 0 has first priority.
  - In-flight reads are discarded; no response is ever produced for a read granted before reset.
- Handshake:
  - A request transfers in the cycle where valid && ready.
  - Requesters hold addr/data stable while valid && !ready.
  - ready is at most one-hot per port and never asserted without the matching valid.
- Round-robin, per port:
  - Search starts at last_grant+1 modulo N and wraps.
  - The first valid requester wins.
  - The pointer updates to the winner only on an actual grant.
  - With no valid request, there is no grant and the pointer holds.
- Write path:
  - Grant in cycle T registers the winner's addr/data into mem_wr_* with mem_wr_en=1 in T+1.
  - mem_wr_en=0 in any cycle following a no-grant cycle.
- Read path:
  - Grant in cycle T drives mem_rd_en=1 and mem_rd_addr in T+1.
  - A shift pipe carries valid+ID.
  - rsp_valid=1, rsp_id=winner, rsp_data=mem_dout in T+2.
  - Fixed 2-cycle grant-to-response latency.
  - One read accepted per cycle, no bubbles.
- Same-cycle hazard:
  - If the read winner's address equals the write winner's address in cycle T, the read is NOT granted (rd_req_ready all 0) and the read pointer holds.
  - The write proceeds; the read wins next cycle and returns the new data.
  - A read granted in T+1 against a write granted in T sees the written data, since the SRAM commits at the end of T+1.
- No response backpressure: consumers must accept rsp_valid unconditionally.
- Data width: rsp_data is exactly DW bits; no transformation of data.

Decomposition:
- Package sram_arb_pkg:
  - AW/DW defaults.
  - Typedef addr_t = logic [AW-1:0].
  - Typedef data_t = logic [DW-1:0].
- Sub-module rr_arbiter (param N): inputs req, advance; outputs one-hot gnt, gnt_idx.
  - Owns the pointer register.
  - Instantiated twice: write port and read port.
- The hazard compare and the pipelines stay in the top.

Test Plan:
- Reset then single read: rd_req_valid=4'b0010, addr 14'h0005 held 1 cycle after a prior write of 16'hBEEF to 5 -> rd_req_ready=4'b0010 at T, mem_rd_en at T+1, rsp_valid/rsp_id=1/rsp_data=16'hBEEF at T+2.
- Write fairness: all 4 wr_req_valid held high 8 cycles -> grants 0,1,2,3,0,1,2,3; mem_wr_en high 8 consecutive cycles starting one cycle after first grant.
- Pointer hold: requester 2 only for 1 cycle, then requesters 0 and 3 both valid -> grant order 2,3,0.
- Hazard: write requester 0 addr 14'h0100 data 16'h1234 and read requester 1 addr 14'h0100 same cycle -> write granted, rd_req_ready=0; read granted next cycle; rsp_data=16'h1234.
- Back-to-back reads from requesters 0..3 to addrs 0..3 preloaded with 16'hA000..16'hA003 -> four consecutive rsp_valid cycles, IDs 0,1,2,3, matching data.
- Reset mid-flight: assert rst_n=0 the cycle after a read grant -> rsp_valid stays 0, mem_*_en=0 immediately; after release, first new request is served by requester 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared constants and types for the packet-SRAM port arbiter.
package sram_arb_pkg;
  localparam int SRAM_AW = 14;
  localparam int SRAM_DW = 16;
  // Grant-to-response latency of the read path
  localparam int RD_LAT  = 2;

  typedef logic [SRAM_AW-1:0] addr_t;
  typedef logic [SRAM_DW-1:0] data_t;
endpackage

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last winner; the pointer
// moves only when the caller confirms the grant through advance.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end

  // Pointer starts at the last index so requester 0 is first after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ptr <= IW'(N - 1);
    else if (advance && found) ptr <= gnt_idx;
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates N_WR writers and N_RD readers onto a 1W/1R SRAM and returns
// read data tagged with the requester ID after a fixed latency.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int N_WR = 4,
  parameter int N_RD = 4,
  parameter int AW   = SRAM_AW,
  parameter int DW   = SRAM_DW,
  parameter int IDW  = $clog2(N_RD)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_WR-1:0]    wr_req_valid,
  input  logic [N_WR*AW-1:0] wr_req_addr,
  input  logic [N_WR*DW-1:0] wr_req_data,
  output logic [N_WR-1:0]    wr_req_ready,
  input  logic [N_RD-1:0]    rd_req_valid,
  input  logic [N_RD*AW-1:0] rd_req_addr,
  output logic [N_RD-1:0]    rd_req_ready,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_data,
  output logic               mem_wr_en,
  output logic [AW-1:0]      mem_wr_addr,
  output logic [DW-1:0]      mem_din,
  output logic               mem_rd_en,
  output logic [AW-1:0]      mem_rd_addr,
  input  logic [DW-1:0]      mem_dout
);
  localparam int WIW    = $clog2(N_WR);
  localparam int STAGES = RD_LAT - 1;

  logic [N_WR-1:0][AW-1:0] wr_addr_a;
  logic [N_WR-1:0][DW-1:0] wr_data_a;
  logic [N_RD-1:0][AW-1:0] rd_addr_a;
  assign wr_addr_a = wr_req_addr;
  assign wr_data_a = wr_req_data;
  assign rd_addr_a = rd_req_addr;

  logic [N_WR-1:0] wr_gnt;
  logic [WIW-1:0]  wr_idx;
  logic [N_RD-1:0] rd_gnt;
  logic [IDW-1:0]  rd_idx;
  logic            wr_any, rd_any, hazard, rd_fire;

  assign wr_any = |wr_req_valid;
  assign rd_any = |rd_req_valid;
  // A same-address read would see pre-write data; defer it one cycle
  assign hazard  = wr_any && rd_any && (rd_addr_a[rd_idx] == wr_addr_a[wr_idx]);
  assign rd_fire = rd_any && !hazard;

  assign wr_req_ready = wr_gnt;
  assign rd_req_ready = hazard ? '0 : rd_gnt;

  rr_arbiter #(.N(N_WR)) u_wr_arb (
    .clk(clk), .rst_n(rst_n), .req(wr_req_valid), .advance(wr_any),
    .gnt(wr_gnt), .gnt_idx(wr_idx)
  );

  rr_arbiter #(.N(N_RD)) u_rd_arb (
    .clk(clk), .rst_n(rst_n), .req(rd_req_valid), .advance(rd_fire),
    .gnt(rd_gnt), .gnt_idx(rd_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_din     <= '0;
    end else begin
      mem_wr_en <= wr_any;
      if (wr_any) begin
        mem_wr_addr <= wr_addr_a[wr_idx];
        mem_din     <= wr_data_a[wr_idx];
      end
    end
  end

  // vld_pipe[0] is the SRAM read strobe, vld_pipe[STAGES] the response strobe
  logic [STAGES:0]          vld_pipe;
  logic [STAGES:0][IDW-1:0] id_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe    <= '0;
      id_pipe     <= '0;
      mem_rd_addr <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], rd_fire};
      id_pipe  <= {id_pipe[STAGES-1:0], rd_idx};
      if (rd_fire) mem_rd_addr <= rd_addr_a[rd_idx];
    end
  end

  assign mem_rd_en = vld_pipe[0];
  assign rsp_valid = vld_pipe[STAGES];
  assign rsp_id    = id_pipe[STAGES];
  assign rsp_data  = mem_dout;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Table-driven bench for sram_port_arbiter with an SRAM model and a response scoreboard.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int N_WR = 4;
  localparam int N_RD = 4;
  localparam int AW   = 14;
  localparam int DW   = 16;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N_WR-1:0]         wr_req_valid, wr_req_ready;
  logic [N_WR-1:0][AW-1:0] wr_req_addr;
  logic [N_WR-1:0][DW-1:0] wr_req_data;
  logic [N_RD-1:0]         rd_req_valid, rd_req_ready;
  logic [N_RD-1:0][AW-1:0] rd_req_addr;
  logic                    rsp_valid;
  logic [IDW-1:0]          rsp_id;
  logic [DW-1:0]           rsp_data, mem_din, mem_dout;
  logic                    mem_wr_en, mem_rd_en;
  logic [AW-1:0]           mem_wr_addr, mem_rd_addr;

  sram_port_arbiter #(.N_WR(N_WR), .N_RD(N_RD), .AW(AW), .DW(DW), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .wr_req_ready(wr_req_ready),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_din(mem_din),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_dout(mem_dout)
  );

  // SRAM model: registered read, write commits at the clock edge
  data_t sram    [0:16383];
  data_t ref_mem [0:16383];
  always @(posedge clk) begin
    if (mem_wr_en) sram[mem_wr_addr] <= mem_din;
    if (mem_rd_en) mem_dout <= sram[mem_rd_addr];
  end

  typedef struct { logic [IDW-1:0] id; data_t data; int due; } exp_t;
  exp_t sbq[$];

  typedef struct { logic [3:0] wv, rv, ew, er; addr_t wa, ra; data_t wd; } vec_t;
  vec_t tbl[$];

  int nvec  = 0;
  int nerr  = 0;
  int cyc_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] oh_idx(input logic [3:0] v);
    casez (v)
      4'b???1: return 2'd0;
      4'b??10: return 2'd1;
      4'b?100: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  task automatic drive(input logic [3:0] wv, input addr_t wa, input data_t wd,
                       input logic [3:0] rv, input addr_t ra);
    wr_req_valid = wv;
    rd_req_valid = rv;
    wr_req_addr  = {wa + 14'd3, wa + 14'd2, wa + 14'd1, wa};
    wr_req_data  = {wd + 16'd3, wd + 16'd2, wd + 16'd1, wd};
    rd_req_addr  = {ra + 14'd3, ra + 14'd2, ra + 14'd1, ra};
  endtask

  // Called exactly once per cycle at the falling edge
  task automatic sb_step();
    exp_t       e;
    logic [1:0] i;
    logic       due_now;
    cyc_n++;
    if (!rst_n) begin
      sbq.delete();
      chk("rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
      return;
    end
    if (|rd_req_ready) begin
      i      = oh_idx(rd_req_ready);
      e.id   = i;
      e.data = ref_mem[rd_req_addr[i]];
      e.due  = cyc_n + 2;
      sbq.push_back(e);
    end
    if (|wr_req_ready) begin
      i = oh_idx(wr_req_ready);
      ref_mem[wr_req_addr[i]] = wr_req_data[i];
    end
    due_now = (sbq.size() > 0) && (sbq[0].due == cyc_n);
    chk("rsp_valid", 32'(rsp_valid), 32'(due_now));
    if (due_now) begin
      e = sbq.pop_front();
      if (rsp_valid) begin
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    sb_step();
  endtask

  task automatic add(input logic [3:0] wv, input addr_t wa, input data_t wd,
                     input logic [3:0] rv, input addr_t ra,
                     input logic [3:0] ew, input logic [3:0] er);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra; v.ew = ew; v.er = er;
    tbl.push_back(v);
  endtask

  initial begin
    vec_t       v, p;
    logic [1:0] i;

    rst_n = 1'b0;
    drive('0, '0, '0, '0, '0);
    cyc();
    cyc();
    chk("rst_mem_wr_en",   32'(mem_wr_en),    32'd0);
    chk("rst_mem_rd_en",   32'(mem_rd_en),    32'd0);
    chk("rst_mem_wr_addr", 32'(mem_wr_addr),  32'd0);
    chk("rst_mem_rd_addr", 32'(mem_rd_addr),  32'd0);
    chk("rst_mem_din",     32'(mem_din),      32'd0);
    chk("rst_rsp_id",      32'(rsp_id),       32'd0);
    chk("rst_wr_ready",    32'(wr_req_ready), 32'd0);
    chk("rst_rd_ready",    32'(rd_req_ready), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc();

    // write fairness: all four held for eight cycles
    for (int k = 0; k < 8; k++)
      add(4'b1111, 14'h10, 16'h1000, 4'b0, '0, 4'(1 << (k % 4)), 4'b0);
    add(4'b0000, '0, '0, 4'b0, '0, 4'b0000, 4'b0);
    // pointer hold: 2 alone, then 0 and 3 -> 2,3,0
    add(4'b0100, 14'h20, 16'h2000, 4'b0, '0, 4'b0100, 4'b0);
    add(4'b1001, 14'h20, 16'h2000, 4'b0, '0, 4'b1000, 4'b0);
    add(4'b1001, 14'h20, 16'h2000, 4'b0, '0, 4'b0001, 4'b0);
    // BEEF to address 5 by requester 1, then read it back via requester 1
    add(4'b0010, 14'h4, 16'hBEEE, 4'b0, '0, 4'b0010, 4'b0);
    add(4'b0000, '0, '0, 4'b0000, '0, 4'b0000, 4'b0000);
    add(4'b0000, '0, '0, 4'b0010, 14'h4, 4'b0000, 4'b0010);
    add(4'b0000, '0, '0, 4'b0000, '0, 4'b0000, 4'b0000);
    add(4'b0000, '0, '0, 4'b0000, '0, 4'b0000, 4'b0000);
    // same-address hazard: read deferred one cycle, returns 1234
    add(4'b0001, 14'h100, 16'h1234, 4'b0010, 14'hFF, 4'b0001, 4'b0000);
    add(4'b0000, '0, '0, 4'b0010, 14'hFF, 4'b0000, 4'b0010);
    // preload A000..A003 at 0..3 (write pointer sits at 0)
    add(4'b1111, 14'h0, 16'hA000, 4'b0, '0, 4'b0010, 4'b0);
    add(4'b1111, 14'h0, 16'hA000, 4'b0, '0, 4'b0100, 4'b0);
    add(4'b1111, 14'h0, 16'hA000, 4'b0, '0, 4'b1000, 4'b0);
    add(4'b1111, 14'h0, 16'hA000, 4'b0, '0, 4'b0001, 4'b0);
    add(4'b0000, '0, '0, 4'b0000, '0, 4'b0000, 4'b0000);
    // back-to-back reads, requester i reads address i
    add(4'b0000, '0, '0, 4'b0001, 14'h0, 4'b0000, 4'b0001);
    add(4'b0000, '0, '0, 4'b0010, 14'h0, 4'b0000, 4'b0010);
    add(4'b0000, '0, '0, 4'b0100, 14'h0, 4'b0000, 4'b0100);
    add(4'b0000, '0, '0, 4'b1000, 14'h0, 4'b0000, 4'b1000);
    // mixed read and write to distinct addresses in one cycle
    add(4'b0100, 14'h40, 16'h4000, 4'b0001, 14'h2, 4'b0100, 4'b0001);
    for (int k = 0; k < 3; k++)
      add(4'b0000, '0, '0, 4'b0000, '0, 4'b0000, 4'b0000);

    p.ew = '0; p.er = '0; p.wa = '0; p.ra = '0; p.wd = '0; p.wv = '0; p.rv = '0;
    for (int k = 0; k < tbl.size(); k++) begin
      v = tbl[k];
      @(posedge clk); #1 drive(v.wv, v.wa, v.wd, v.rv, v.ra);
      cyc();
      chk($sformatf("wr_ready[%0d]", k), 32'(wr_req_ready), 32'(v.ew));
      chk($sformatf("rd_ready[%0d]", k), 32'(rd_req_ready), 32'(v.er));
      chk($sformatf("mem_wr_en[%0d]", k), 32'(mem_wr_en), 32'(|p.ew));
      if (|p.ew) begin
        i = oh_idx(p.ew);
        chk($sformatf("mem_wr_addr[%0d]", k), 32'(mem_wr_addr), 32'(p.wa + 14'(i)));
        chk($sformatf("mem_din[%0d]", k), 32'(mem_din), 32'(p.wd + 16'(i)));
      end
      chk($sformatf("mem_rd_en[%0d]", k), 32'(mem_rd_en), 32'(|p.er));
      if (|p.er) begin
        i = oh_idx(p.er);
        chk($sformatf("mem_rd_addr[%0d]", k), 32'(mem_rd_addr), 32'(p.ra + 14'(i)));
      end
      p = v;
    end

    // reset one cycle after a read grant: the in-flight read must vanish
    @(posedge clk); #1 drive(4'b0100, 14'h300, 16'h5555, 4'b0001, 14'h200);
    cyc();
    chk("mf_wr_ready", 32'(wr_req_ready), 32'b0100);
    chk("mf_rd_ready", 32'(rd_req_ready), 32'b0001);
    @(posedge clk); #1;
    chk("mf_pre_rd_en", 32'(mem_rd_en), 32'd1);
    chk("mf_pre_wr_en", 32'(mem_wr_en), 32'd1);
    rst_n = 1'b0;
    drive('0, '0, '0, '0, '0);
    #1;
    chk("mf_rd_en", 32'(mem_rd_en), 32'd0);
    chk("mf_wr_en", 32'(mem_wr_en), 32'd0);
    chk("mf_rsp_valid", 32'(rsp_valid), 32'd0);
    cyc();
    cyc();
    cyc();
    @(posedge clk); #1 rst_n = 1'b1;
    drive(4'b1111, 14'h300, 16'h7000, 4'b1111, 14'h0);
    cyc();
    chk("post_rst_wr_ready", 32'(wr_req_ready), 32'b0001);
    chk("post_rst_rd_ready", 32'(rd_req_ready), 32'b0001);
    @(posedge clk); #1 drive('0, '0, '0, '0, '0);
    for (int k = 0; k < 4; k++) cyc();
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
